// File: rtl/softmax_exp_sched.sv
// softmax_exp_sched: time-shares one external exp unit across a softmax vector, buffering results and their sum.
// Optional SOFTMAX_SAT_CNT_EN adds sat_cnt, the per-vector count of clamped inputs.
module softmax_exp_sched #(
  parameter int VEC_LEN = 16,
  parameter int IDX_W = $clog2(VEC_LEN),
  parameter int ACC_W = 32 + IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      in_x,
  input  logic             in_last,
  output logic [16:0]      exp_x,
  input  logic [20:0]      exp_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [20:0]      out_exp,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  output logic             busy,
  output logic             len_err
`ifdef SOFTMAX_SAT_CNT_EN
  ,
  output logic [IDX_W:0]   sat_cnt
`endif
);
  localparam int SW = (ACC_W > 48 ? ACC_W : 48) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t state, state_d;
  logic [20:0] mem [VEC_LEN];
  logic [IDX_W:0] wr_ptr, in_idx;
  logic [IDX_W-1:0] rd_ptr;
  logic cap_pend, in_hs, out_hs, first_hs, last_hs, full_hs, over;
  logic [16:0] clamped;
  logic [SW-1:0] term, tot;
  always_comb begin
    over = in_x[15:12] > 4'd10;
    clamped = over ? {in_x[16], 4'd10, 12'd0} : (in_x == 17'h10000 ? 17'h00000 : in_x);
    in_hs = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    first_hs = in_hs && state == IDLE;
    // the element being accepted sits one slot past the captures still in flight
    in_idx = wr_ptr + (IDX_W+1)'(cap_pend);
    full_hs = in_hs && !in_last && in_idx == (IDX_W+1)'(VEC_LEN-1);
    last_hs = in_last || in_idx == (IDX_W+1)'(VEC_LEN-1);
    term = SW'(exp_y[15:0]) << exp_y[20:16];
    tot = SW'(sum) + term;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, LOAD: if (in_hs) state_d = last_hs ? FLUSH : LOAD;
      FLUSH: state_d = DRAIN;
      DRAIN: if (out_hs && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE || state == LOAD;
    out_valid = state == DRAIN;
    busy = state != IDLE;
    out_exp = out_valid ? mem[rd_ptr] : 21'd0;
    out_idx = rd_ptr;
    out_last = out_valid && {1'b0, rd_ptr} == wr_ptr - 1'b1;
  end
  always_ff @(posedge clk)
    if (cap_pend) mem[wr_ptr[IDX_W-1:0]] <= exp_y;
  always_ff @(posedge clk)
    if (!rst_n) begin
      exp_x <= '0;
      cap_pend <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      sum <= '0;
      sum_valid <= 1'b0;
      len_err <= 1'b0;
    end else begin
      if (in_hs) exp_x <= clamped;
      cap_pend <= in_hs;
      if (out_hs && out_last) wr_ptr <= '0;
      else if (cap_pend) wr_ptr <= wr_ptr + 1'b1;
      if (state == FLUSH || (out_hs && out_last)) rd_ptr <= '0;
      else if (out_hs) rd_ptr <= rd_ptr + 1'b1;
      if (first_hs) sum <= '0;
      else if (cap_pend) sum <= |tot[SW-1:ACC_W] ? {ACC_W{1'b1}} : tot[ACC_W-1:0];
      if (state == FLUSH) sum_valid <= 1'b1;
      else if (out_hs && out_last) sum_valid <= 1'b0;
      len_err <= first_hs ? 1'b0 : (len_err || full_hs);
    end
`ifdef SOFTMAX_SAT_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n) sat_cnt <= '0;
    else if (first_hs) sat_cnt <= (IDX_W+1)'(over);
    else if (in_hs && over) sat_cnt <= sat_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_softmax_exp_sched.sv
// tb_softmax_exp_sched: directed vectors against softmax_exp_sched with a stubbed exp unit.
module tb_softmax_exp_sched;
  localparam int VEC_LEN = 16;
  localparam int IDX_W = 4;
  localparam int ACC_W = 36;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [16:0] in_x = '0;
  logic in_last = 1'b0;
  logic [16:0] exp_x;
  logic [20:0] exp_y;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [20:0] out_exp;
  logic [IDX_W-1:0] out_idx;
  logic out_last;
  logic [ACC_W-1:0] sum;
  logic sum_valid, busy, len_err;
`ifdef SOFTMAX_SAT_CNT_EN
  logic [IDX_W:0] sat_cnt;
`endif
  logic fn = 1'b0;
  logic [20:0] stub = '0;
  logic [20:0] ex [64];
  int total = 0;
  int bad = 0;
  assign exp_y = fn ? {5'd0, exp_x[15:0]} : stub;
  always #5 clk = ~clk;
  softmax_exp_sched #(.VEC_LEN(VEC_LEN), .IDX_W(IDX_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_last(in_last), .exp_x(exp_x), .exp_y(exp_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_exp(out_exp), .out_idx(out_idx), .out_last(out_last),
    .sum(sum), .sum_valid(sum_valid), .busy(busy), .len_err(len_err)
`ifdef SOFTMAX_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [16:0] x, input logic last, input int gap);
    in_valid = 1'b1;
    in_x = x;
    in_last = last;
    chk("in_ready", 64'(in_ready), 64'd1);
    tick(1);
    in_valid = 1'b0;
    in_last = 1'b0;
    tick(gap);
  endtask
  task automatic fill(input logic [20:0] v);
    for (int i = 0; i < 64; i++) ex[i] = v;
  endtask
  task automatic drain(input int n, input logic [3:0] pat, input logic [ACC_W-1:0] esum);
    int k = 0;
    int t = 0;
    while (k < n && t < 300) begin
      out_ready = pat[t%4];
      #1;
      if (out_valid) begin
        chk("out_idx", 64'(out_idx), 64'(k));
        chk("out_exp", 64'(out_exp), 64'(ex[k]));
        chk("out_last", 64'(out_last), 64'(k == n - 1));
        chk("sum", 64'(sum), 64'(esum));
        chk("sum_valid", 64'(sum_valid), 64'd1);
        if (out_ready) k++;
      end
      tick(1);
      t++;
    end
    out_ready = 1'b0;
    chk("drained", 64'(k), 64'(n));
    chk("busy_end", 64'(busy), 64'd0);
    chk("sum_valid_end", 64'(sum_valid), 64'd0);
    chk("sum_kept", 64'(sum), 64'(esum));
  endtask
  task automatic reset_vals();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_exp_x", 64'(exp_x), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_exp", 64'(out_exp), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_sum_valid", 64'(sum_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
  endtask
  initial begin
    tick(2);
    reset_vals();
    rst_n = 1'b1;
    tick(1);
    stub = {5'd1, 16'h4000};
    fill(21'h014000);
    for (int i = 0; i < 4; i++) send(17'h00000, i == 3, 0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_busy", 64'(busy), 64'd1);
    tick(1);
    chk("drain_out_valid", 64'(out_valid), 64'd1);
    drain(4, 4'b1111, 36'h20000);
    fn = 1'b1;
    send(17'h0F000, 1'b0, 0);
    chk("clamp_pos", 64'(exp_x), 64'h0A000);
    send(17'h1C800, 1'b0, 0);
    chk("clamp_neg", 64'(exp_x), 64'h1A000);
    send(17'h10000, 1'b1, 0);
    chk("clamp_negzero", 64'(exp_x), 64'h00000);
    ex[0] = 21'h00A000;
    ex[1] = 21'h00A000;
    ex[2] = 21'h000000;
    drain(3, 4'b1001, 36'h14000);
`ifdef SOFTMAX_SAT_CNT_EN
    chk("sat_cnt", 64'(sat_cnt), 64'd2);
`endif
    for (int i = 0; i < 5; i++) begin
      ex[i] = {5'd0, 4'(i + 1), 12'd0};
      send({1'b0, 4'(i + 1), 12'd0}, i == 4, 0);
    end
    drain(5, 4'b1001, 36'h0F000);
    fn = 1'b0;
    stub = {5'd0, 16'h0001};
    fill(21'h000001);
    for (int i = 0; i < 16; i++) send(17'h00100, 1'b0, 0);
    chk("len_err", 64'(len_err), 64'd1);
    chk("len_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    tick(2);
    chk("ignored_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    drain(16, 4'b1111, 36'h10);
    chk("len_err_sticky", 64'(len_err), 64'd1);
    stub = {5'd16, 16'hFFFF};
    fill(21'h10FFFF);
    for (int i = 0; i < 16; i++) send(17'h00000, i == 15, 0);
    chk("len_err_clear", 64'(len_err), 64'd0);
    drain(16, 4'b1111, 36'hF_FFF0_0000);
    for (int i = 0; i < 16; i++) send(17'h00000, i == 15, (i % 3) + 1);
    drain(16, 4'b1111, 36'hF_FFF0_0000);
    stub = {5'd31, 16'hFFFF};
    fill(21'h1FFFFF);
    send(17'h00000, 1'b0, 0);
    send(17'h00000, 1'b1, 0);
    drain(2, 4'b1111, 36'hF_FFFF_FFFF);
    stub = {5'd1, 16'h4000};
    send(17'h00000, 1'b0, 0);
    send(17'h00000, 1'b0, 0);
    rst_n = 1'b0;
    tick(1);
    reset_vals();
    rst_n = 1'b1;
    stub = {5'd0, 16'h0100};
    fill(21'h000100);
    for (int i = 0; i < 3; i++) send(17'h00000, i == 2, 0);
    drain(3, 4'b1111, 36'h300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
